// File: rtl/bit_serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice and a carry flop, LSB first.
// START/BUSY/DONE handshake; RESULT carries WIDTH+1 bits plus a signed-overflow flag.
module bit_serial_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH:0]   RESULT,
  output logic             OVF
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SHIFT     = 2'd1;
  localparam logic [1:0] ST_LOAD_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_count;
  logic             r_carry;
  logic             r_mode;
  logic             r_c_msb_in;
  logic             r_done;
  logic [WIDTH:0]   r_result;
  logic             r_ovf;

  logic             w_s;
  logic             w_c;
  logic             w_last;
  logic             w_pre_last;

  assign {w_c, w_s}  = {1'b0, r_a[0]} + {1'b0, r_b[0]} + {1'b0, r_carry};
  assign w_last      = (r_count == CNT_W'(WIDTH - 1));
  assign w_pre_last  = (r_count == CNT_W'(WIDTH - 2));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (START) w_state_nxt = ST_SHIFT;
      ST_SHIFT:     if (w_last) w_state_nxt = ST_LOAD_DONE;
      ST_LOAD_DONE: w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= ST_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_sum      <= '0;
      r_count    <= '0;
      r_carry    <= 1'b0;
      r_mode     <= 1'b0;
      r_c_msb_in <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == ST_LOAD_DONE);
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
            r_a     <= A;
            r_b     <= SUB ? ~B : B;
            r_carry <= SUB;
            r_mode  <= SUB;
            r_count <= '0;
            r_sum   <= '0;
          end
        end
        ST_SHIFT: begin
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_sum   <= {w_s, r_sum[WIDTH-1:1]};
          r_carry <= w_c;
          r_count <= r_count + CNT_W'(1);
          if (w_pre_last) r_c_msb_in <= w_c;
        end
        ST_LOAD_DONE: begin
          // For subtraction the carry-out is the inverted borrow.
          r_result <= {(r_mode ? ~r_carry : r_carry), r_sum};
          r_ovf    <= r_c_msb_in ^ r_carry;
        end
        default: ;
      endcase
    end
  end

  assign BUSY   = (r_state == ST_SHIFT) || (r_state == ST_LOAD_DONE);
  assign DONE   = r_done;
  assign RESULT = r_result;
  assign OVF    = r_ovf;

endmodule

// File: tb/tb_bit_serial_addsub.sv
// Scoreboard bench for bit_serial_addsub: 8-bit and 16-bit instances, directed and random
// operations checked against an integer-arithmetic reference model.
module tb_bit_serial_addsub;

  typedef struct {
    logic [16:0] res;
    logic        ovf;
    int          start;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic        start8 = 1'b0, sub8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, ovf8;
  logic [8:0]  res8;

  logic        start16 = 1'b0, sub16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, ovf16;
  logic [16:0] res16;

  exp_t q8[$];
  exp_t q16[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bit_serial_addsub #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst_n), .START(start8), .SUB(sub8), .A(a8), .B(b8),
    .BUSY(busy8), .DONE(done8), .RESULT(res8), .OVF(ovf8)
  );

  bit_serial_addsub #(.WIDTH(16)) dut16 (
    .CLK(clk), .RST(rst_n), .START(start16), .SUB(sub16), .A(a16), .B(b16),
    .BUSY(busy16), .DONE(done16), .RESULT(res16), .OVF(ovf16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned/signed integer arithmetic on w-bit operands.
  function automatic exp_t model(input int w, input int a, input int b, input bit sub,
                                 input int start);
    exp_t e;
    int   full, sa, sb, sr;
    full = 1 << w;
    sa = (a >= full / 2) ? a - full : a;
    sb = (b >= full / 2) ? b - full : b;
    if (sub) begin
      e.res = 17'((a - b + 2 * full) % (2 * full));
      sr    = sa - sb;
    end else begin
      e.res = 17'(a + b);
      sr    = sa + sb;
    end
    e.ovf   = (sr >= full / 2) || (sr < -(full / 2));
    e.start = start;
    return e;
  endfunction

  // 8-bit monitor: pops the scoreboard on DONE, also checks pulse width, BUSY length, hold.
  int         run8 = 0, last_run8 = 0;
  logic [9:0] prev8 = '0;
  logic       pdone8 = 1'b0;
  exp_t       m8;
  always @(negedge clk) begin
    if (!rst_n) run8 = 0;
    else if (busy8) run8++;
    else begin
      if (run8 != 0) last_run8 = run8;
      run8 = 0;
    end
    if (rst_n && !done8) check("hold8", {res8, ovf8}, prev8);
    prev8 = {res8, ovf8};
    if (done8) begin
      check("pulse8", pdone8, 0);
      check("busy_len8", last_run8, 9);
      if (q8.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done8: got DONE with empty scoreboard (t=%0t)", $time);
      end else begin
        m8 = q8.pop_front();
        check("result8", res8, m8.res);
        check("ovf8", ovf8, m8.ovf);
        check("latency8", cyc - m8.start, 9);
      end
    end
    pdone8 = done8;
  end

  exp_t m16;
  always @(negedge clk) begin
    if (done16) begin
      if (q16.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done16: got DONE with empty scoreboard (t=%0t)", $time);
      end else begin
        m16 = q16.pop_front();
        check("result16", res16, m16.res);
        check("ovf16", ovf16, m16.ovf);
        check("latency16", cyc - m16.start, 17);
      end
    end
  end

  task automatic wait_idle8();
    int n = 0;
    @(negedge clk);
    while (busy8 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy8) check("idle_timeout8", busy8, 0);
  endtask

  task automatic wait_idle16();
    int n = 0;
    @(negedge clk);
    while (busy16 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy16) check("idle_timeout16", busy16, 0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q8.size() != 0 || q16.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", q8.size() + q16.size(), 0);
  endtask

  // Issue one 8-bit op; with garble, inputs are scrambled for the whole busy window.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit sub, input bit garble);
    wait_idle8();
    a8 = a; b8 = b; sub8 = sub; start8 = 1'b1;
    q8.push_back(model(8, int'(a), int'(b), sub, cyc + 1));
    @(negedge clk);
    if (garble) begin
      for (int j = 0; j <= 8; j++) begin
        start8 = (j == 8) ? 1'b1 : 1'($urandom);
        a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
        @(negedge clk);
      end
    end
    start8 = 1'b0;
  endtask

  task automatic dir8(input logic [7:0] a, input logic [7:0] b, input bit sub,
                      input logic [8:0] er, input logic eo);
    op8(a, b, sub, 1'b0);
    wait_drain();
    check("dir_result8", res8, er);
    check("dir_ovf8", ovf8, eo);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input bit sub);
    wait_idle16();
    a16 = a; b16 = b; sub16 = sub; start16 = 1'b1;
    q16.push_back(model(16, int'(a), int'(b), sub, cyc + 1));
    @(negedge clk);
    start16 = 1'b0;
  endtask

  task automatic b2b8(input int n);
    wait_idle8();
    start8 = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        wait_idle8();
        check("b2b_in_done_cycle", done8, 1);
      end
      a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
      q8.push_back(model(8, int'(a8), int'(b8), sub8, cyc + 1));
    end
    @(negedge clk);
    start8 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_result8", {res8, ovf8}, 0);
    check("rst_result16", {res16, ovf16, busy16, done16}, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    dir8(8'd100, 8'd200, 1'b0, 9'h12C, 1'b0);
    dir8(8'h7F, 8'h01, 1'b0, 9'h080, 1'b1);
    dir8(8'hFF, 8'hFF, 1'b0, 9'h1FE, 1'b0);
    dir8(8'd3, 8'd5, 1'b1, 9'h1FE, 1'b0);
    dir8(8'h80, 8'h01, 1'b1, 9'h07F, 1'b1);

    op8(8'd10, 8'd20, 1'b0, 1'b1);
    wait_drain();
    check("garble_result8", res8, 9'h01E);

    b2b8(4);
    for (int i = 0; i < 30; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    wait_drain();

    // Abort mid-operation: outputs clear at once, no DONE follows.
    wait_idle8();
    a8 = 8'hC3; b8 = 8'h5A; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy8", busy8, 0);
    check("abort_done8", done8, 0);
    check("abort_result8", res8, 0);
    check("abort_ovf8", ovf8, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    dir8(8'd1, 8'd1, 1'b0, 9'h002, 1'b0);

    op16(16'hFFFF, 16'h0001, 1'b0);
    wait_drain();
    check("dir_result16a", res16, 17'h10000);
    check("dir_ovf16a", ovf16, 1'b0);
    op16(16'h0000, 16'h0001, 1'b1);
    wait_drain();
    check("dir_result16b", res16, 17'h1FFFF);
    check("dir_ovf16b", ovf16, 1'b0);
    for (int i = 0; i < 10; i++)
      op16(16'($urandom), 16'($urandom), 1'($urandom));
    wait_drain();
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
